// File: rtl/pipelined_inverter_if.sv
// pipelined_inverter_if: input/output valid-ready streams of the unary-op pipeline.
interface pipelined_inverter_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    modport master (output in_valid, in_mode, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_ovf);
    modport slave  (input  in_valid, in_mode, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/pipelined_inverter.sv
// pipelined_inverter: elastic DEPTH-stage pass/NOT/negate/abs pipeline with valid/ready.
// INVERTER_COUNT_EN adds a 32-bit output-handshake counter on port beat_count.
module pipelined_inverter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_inverter_if.slave bus,
    output logic busy
`ifdef INVERTER_COUNT_EN
    ,
    output logic [31:0] beat_count
`endif
);
    logic [DEPTH-1:0] v, adv, pv, o, po;
    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH-1:0] pd [DEPTH];
    logic [WIDTH-1:0] neg, res;
    logic             ovf, full;

    always_comb begin
        neg = ~bus.in_data + WIDTH'(1);
        res = bus.in_mode[1] ? ((bus.in_mode[0] && !bus.in_data[WIDTH-1]) ? bus.in_data : neg)
                             : (bus.in_mode[0] ? ~bus.in_data : bus.in_data);
        ovf = bus.in_mode[1] && (bus.in_data == {1'b1, {(WIDTH-1){1'b0}}});
        pv[0] = bus.in_valid;
        pd[0] = res;
        po[0] = ovf;
        for (int k = 1; k < DEPTH; k++) begin
            pv[k] = v[k-1];
            pd[k] = d[k-1];
            po[k] = o[k-1];
        end
        // a stage advances if it or any later stage is empty, or the sink takes a beat
        full = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full   = full & v[k];
            adv[k] = bus.out_ready || !full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            o <= '0;
            for (int k = 0; k < DEPTH; k++) d[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v[k] <= pv[k];
                    d[k] <= pd[k];
                    o[k] <= po[k];
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.out_ovf   = o[DEPTH-1];
    assign busy          = |v;

`ifdef INVERTER_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_count <= '0;
        else if (bus.out_valid && bus.out_ready) beat_count <= beat_count + 32'd1;
    end
`endif
endmodule
